// File: rtl/vm_proj_router_n.sv
// vm_proj_router_n: sorts projection words into NVM virtual-module memories by their select field.
// Optional macro VM_PROJ_DROP_CNT_EN adds drop_cnt (invalid-select plus overflow drops per event).
module vm_proj_router_n #(
  parameter int PROJ_W  = 54,
  parameter int ADDR_W  = 9,
  parameter int NVM     = 3,
  parameter int VM_W    = 13,
  parameter int VM_LSB  = 0,
  parameter int SEL_W   = 3,
  parameter int SEL_LSB = 51
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_proc,
  input  logic [ADDR_W:0]       nproj,
  output logic [ADDR_W-1:0]     read_projection,
  input  logic [PROJ_W-1:0]     projection,
  output logic [NVM-1:0]        wr_en,
  output logic [NVM*ADDR_W-1:0] wr_add,
  output logic [VM_W-1:0]       vm_projection,
  output logic                  busy,
  output logic                  done,
`ifdef VM_PROJ_DROP_CNT_EN
  output logic [ADDR_W:0]       drop_cnt,
`endif
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   nproj_q, nproj_m1;
  logic              start_rd, last_addr, drain_q, slot_vld;
  logic [ADDR_W-1:0] fill_cnt [NVM];
  logic [SEL_W-1:0]  sel;
  logic [NVM-1:0]    sel_hit, chan_full;
  logic              sel_valid, full_hit;
  logic              unused_proj;

  // Only the select and VM fields are consumed; fold the rest so it is visibly intentional.
  assign unused_proj = ^projection;

  assign start_rd  = (state == IDLE) && en_proc && (nproj != '0);
  assign nproj_m1  = nproj_q - {{ADDR_W{1'b0}}, 1'b1};
  // The address bound also stops a count larger than the memory from looping forever.
  assign last_addr = ({1'b0, read_projection} >= nproj_m1) || (&read_projection);
  assign sel       = projection[SEL_LSB +: SEL_W];

  always_comb begin
    sel_hit   = '0;
    chan_full = '0;
    for (int k = 0; k < NVM; k++) begin
      if (32'(sel) == k) sel_hit[k] = 1'b1;
      chan_full[k] = &fill_cnt[k];
    end
    sel_valid = |sel_hit;
    full_hit  = |(sel_hit & chan_full);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_proc) state_nxt = (nproj == '0) ? DONE : READ;
      READ:    if (last_addr) state_nxt = DRAIN;
      DRAIN:   if (drain_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_projection <= '0;
      nproj_q         <= '0;
      drain_q         <= 1'b0;
      slot_vld        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      slot_vld <= (state == READ);
      drain_q  <= (state == DRAIN) && !drain_q;
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      if (start_rd) begin
        nproj_q         <= nproj;
        read_projection <= '0;
      end else if ((state == READ) && !last_addr) begin
        read_projection <= read_projection + ADDR_W'(1);
      end
    end
  end

  // Write stage: the top address of every VM memory is the full marker and is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en         <= '0;
      wr_add        <= '0;
      vm_projection <= '0;
      overflow      <= 1'b0;
      for (int k = 0; k < NVM; k++) fill_cnt[k] <= '0;
`ifdef VM_PROJ_DROP_CNT_EN
      drop_cnt      <= '0;
`endif
    end else begin
      wr_en <= '0;
      if (start_rd) begin
        overflow <= 1'b0;
        for (int k = 0; k < NVM; k++) fill_cnt[k] <= '0;
`ifdef VM_PROJ_DROP_CNT_EN
        drop_cnt <= '0;
`endif
      end else if (slot_vld) begin
        vm_projection <= projection[VM_LSB +: VM_W];
        for (int k = 0; k < NVM; k++) begin
          if (sel_hit[k] && !chan_full[k]) begin
            wr_en[k]                     <= 1'b1;
            wr_add[k*ADDR_W +: ADDR_W]   <= fill_cnt[k];
            fill_cnt[k]                  <= fill_cnt[k] + ADDR_W'(1);
          end
        end
        if (full_hit) overflow <= 1'b1;
`ifdef VM_PROJ_DROP_CNT_EN
        if ((!sel_valid || full_hit) && (drop_cnt != '1))
          drop_cnt <= drop_cnt + (ADDR_W+1)'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_vm_proj_router_n.sv
// Bench for vm_proj_router_n: random projections, a list-level routing model feeding a scoreboard,
// and a monitor that pops expectations whenever the router writes or signals done.
module tb_vm_proj_router_n;

  localparam int PROJ_W  = 54;
  localparam int ADDR_W  = 4;
  localparam int NVM     = 3;
  localparam int VM_W    = 13;
  localparam int VM_LSB  = 0;
  localparam int SEL_W   = 3;
  localparam int SEL_LSB = 51;
  localparam int DEPTH   = 1 << ADDR_W;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  en_proc = 1'b0;
  logic [ADDR_W:0]       nproj = '0;
  logic [ADDR_W-1:0]     read_projection;
  logic [PROJ_W-1:0]     projection = '0;
  logic [NVM-1:0]        wr_en;
  logic [NVM*ADDR_W-1:0] wr_add;
  logic [VM_W-1:0]       vm_projection;
  logic                  busy, done, overflow;
`ifdef VM_PROJ_DROP_CNT_EN
  logic [ADDR_W:0]       drop_cnt;
`endif

  vm_proj_router_n #(
    .PROJ_W(PROJ_W), .ADDR_W(ADDR_W), .NVM(NVM), .VM_W(VM_W),
    .VM_LSB(VM_LSB), .SEL_W(SEL_W), .SEL_LSB(SEL_LSB)
  ) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .nproj(nproj),
    .read_projection(read_projection), .projection(projection),
    .wr_en(wr_en), .wr_add(wr_add), .vm_projection(vm_projection),
    .busy(busy), .done(done),
`ifdef VM_PROJ_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Projection memory with a registered read port.
  logic [PROJ_W-1:0] mem [DEPTH];
  always @(posedge clk) projection <= mem[read_projection];

  typedef struct { int cyc; int ch; int addr; int dat; } wr_t;
  typedef struct { int cyc; int ovf; int drops; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    sel_list[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compares every presented write and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (wr_en != '0) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", int'(wr_en), 0);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_en", int'(wr_en), 1 << w.ch);
        check("wr_add", int'(wr_add[w.ch*ADDR_W +: ADDR_W]), w.addr);
        check("vm_projection", int'(vm_projection), w.dat);
        check("write_cycle", cyc, w.cyc);
      end
    end
    if (done == 1'b1) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        done_t d;
        d = exp_done.pop_front();
        check("done_cycle", cyc, d.cyc);
        check("overflow", int'(overflow), d.ovf);
        check("busy_at_done", int'(busy), 1);
        check("pending_writes", exp_wr.size(), 0);
`ifdef VM_PROJ_DROP_CNT_EN
        check("drop_cnt", int'(drop_cnt), d.drops);
`endif
      end
    end
  end

  // One event: load memory, pulse en_proc, build expectations from the routing rules,
  // optionally inject a stray en_proc (mid_off) or a reset (rst_off) relative to the start cycle.
  task automatic run_event(input int n, input int rst_off, input int mid_off);
    int c, ne, ovf, drops, wc, s;
    int fill[NVM];
    logic [PROJ_W-1:0] p;
    ne = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < ne; i++) begin
      s = (i < sel_list.size()) ? sel_list[i] : int'($urandom_range(0, 7));
      p = PROJ_W'({$urandom, $urandom});
      p[SEL_LSB +: SEL_W] = SEL_W'(s);
      mem[i] = p;
    end
    @(posedge clk); #1;
    c = cyc;
    en_proc = 1'b1;
    nproj = (ADDR_W+1)'(n);
    ovf = 0;
    drops = 0;
    foreach (fill[k]) fill[k] = 0;
    for (int i = 0; i < ne; i++) begin
      s  = int'(mem[i][SEL_LSB +: SEL_W]);
      wc = c + 3 + i;
      if (s >= NVM) begin
        drops++;
      end else if (fill[s] == DEPTH - 1) begin
        ovf = 1;
        drops++;
      end else begin
        if (rst_off == 0 || wc <= c + rst_off)
          exp_wr.push_back('{wc, s, fill[s], int'(mem[i][VM_LSB +: VM_W])});
        fill[s]++;
      end
    end
    if (rst_off == 0)
      exp_done.push_back('{(ne == 0) ? c + 1 : c + ne + 3, ovf, drops});
    to_cycle(c + 1);
    en_proc = 1'b0;
    nproj = (ADDR_W+1)'($urandom);
    check("busy_after_start", int'(busy), 1);
    if (ne > 0) check("first_address", int'(read_projection), 0);
    if (mid_off > 0) begin
      to_cycle(c + mid_off);
      en_proc = 1'b1;
      nproj = (ADDR_W+1)'($urandom_range(1, DEPTH));
      to_cycle(c + mid_off + 1);
      en_proc = 1'b0;
    end
    if (rst_off > 0) begin
      to_cycle(c + rst_off);
      reset = 1'b1;
      to_cycle(c + rst_off + 1);
      reset = 1'b0;
      check("wr_en_after_abort", int'(wr_en), 0);
      check("busy_after_abort", int'(busy), 0);
      check("done_after_abort", int'(done), 0);
      check("pending_after_abort", exp_wr.size(), 0);
      repeat (20) begin @(posedge clk); #1; end
    end else begin
      for (int k = 0; k < 300 && exp_done.size() > 0; k++) begin
        @(posedge clk); #1;
      end
      if (exp_done.size() > 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: %0d events still pending, expected 0", exp_done.size());
        exp_done.delete();
        exp_wr.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_projection", int'(read_projection), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_add", int'(wr_add), 0);
    check("rst_vm_projection", int'(vm_projection), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    sel_list = '{0, 1, 2, 0, 1, 2};
    run_event(6, 0, 0);
    sel_list = {};
    run_event(0, 0, 0);
    check("idle_busy_after_empty", int'(busy), 0);
    sel_list = '{3, 7, 1, 3};
    run_event(4, 0, 0);
    sel_list = {};
    for (int i = 0; i < DEPTH; i++) sel_list.push_back(2);
    run_event(DEPTH, 0, 0);
    run_event(3, 0, 0);
    sel_list = {};
    run_event(10, 3, 0);
    check("vm_projection_after_abort", int'(vm_projection), 0);
    run_event(5, 0, 0);
    run_event(8, 0, 4);
    for (int e = 0; e < 25; e++) begin
      int n;
      n = int'($urandom_range(0, DEPTH));
      run_event(n, 0, (n > 3 && $urandom_range(0, 3) == 0) ? 3 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
